// File: rtl/silife_pkg.sv
// Shared encodings for the silife SPI output path: FSM states and SPI mode.
package silife_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // Mode 0: SCK idles low, data launched on falling edge, captured on rising edge.
  localparam spi_mode_t SPI_MODE = '{cpol: 1'b0, cpha: 1'b0};

endpackage

// File: rtl/silife_tick_div.sv
// Half-period tick generator: pulses every CLK_DIV enabled cycles, restartable.
module silife_tick_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic restart_i,
  output logic tick_c_o
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_c_o = en_i && !restart_i && (cnt_q == CNT_W'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_c_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/silife_spi_word_tx.sv
// SPI mode-0 word serializer with CS held across words until a word marked last.
module silife_spi_word_tx
  import silife_pkg::*;
#(
  parameter int unsigned DATA_BITS = 16,
  parameter int unsigned CLK_DIV   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_last,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_busy,
  output logic                 o_cs,
  output logic                 o_sck,
  output logic                 o_mosi
);

  localparam int unsigned BCNT_W = $clog2(DATA_BITS) + 1;

  state_e                state_q, state_d;
  logic                  cs_q, cs_d;
  logic                  sck_q, sck_d;
  logic                  last_q, last_d;
  logic [DATA_BITS-1:0]  shreg_q, shreg_d;
  logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
  logic                  accept_c;
  logic                  tick_c;
  logic                  div_en_c;

  assign o_ready  = (state_q == ST_IDLE) || (state_q == ST_WAIT);
  assign o_busy   = (state_q != ST_IDLE);
  assign o_cs     = cs_q;
  assign o_sck    = sck_q;
  // The shifter MSB is the line itself, so MOSI holds naturally when no shift occurs.
  assign o_mosi   = shreg_q[DATA_BITS-1];

  assign accept_c = i_valid && o_ready;
  assign div_en_c = (state_q == ST_SHIFT) || (state_q == ST_HOLD);

  silife_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_div (
    .clk       (clk),
    .reset     (reset),
    .en_i      (div_en_c),
    .restart_i (accept_c),
    .tick_c_o  (tick_c)
  );

  // Next-state and datapath: SCK toggles on each tick, bits advance on falls.
  always_comb begin
    state_d = state_q;
    cs_d    = cs_q;
    sck_d   = sck_q;
    last_d  = last_q;
    shreg_d = shreg_q;
    bcnt_d  = bcnt_q;

    case (state_q)
      ST_IDLE, ST_WAIT: begin
        if (accept_c) begin
          state_d = ST_SHIFT;
          cs_d    = 1'b0;
          sck_d   = SPI_MODE.cpol;
          shreg_d = i_data;
          last_d  = i_last;
          bcnt_d  = '0;
        end
      end
      ST_SHIFT: begin
        if (tick_c) begin
          if (sck_q == SPI_MODE.cpol) begin
            sck_d = ~SPI_MODE.cpol;
          end else begin
            sck_d = SPI_MODE.cpol;
            if (bcnt_q == BCNT_W'(DATA_BITS - 1)) begin
              bcnt_d = '0;
              if (last_q) begin
                state_d = ST_HOLD;
                cs_d    = 1'b1;
              end else begin
                state_d = ST_WAIT;
              end
            end else begin
              bcnt_d  = bcnt_q + BCNT_W'(1);
              shreg_d = {shreg_q[DATA_BITS-2:0], 1'b0};
            end
          end
        end
      end
      ST_HOLD: begin
        if (tick_c) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cs_q    <= 1'b1;
      sck_q   <= SPI_MODE.cpol;
      last_q  <= 1'b0;
      shreg_q <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      last_q  <= last_d;
      shreg_q <= shreg_d;
      bcnt_q  <= bcnt_d;
    end
  end

endmodule

// File: tb/tb_silife_spi_word_tx.sv
// Bench for silife_spi_word_tx: a 16-bit/div-2 instance and an 8-bit/div-1 instance.
module tb_silife_spi_word_tx;

  localparam int DA = 16;
  localparam int CA = 2;
  localparam int DB = 8;
  localparam int CB = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [DA-1:0] a_data;
  logic          a_last, a_valid, a_ready, a_busy, a_cs, a_sck, a_mosi;
  logic [DB-1:0] b_data;
  logic          b_last, b_valid, b_ready, b_busy, b_cs, b_sck, b_mosi;

  silife_spi_word_tx #(.DATA_BITS(DA), .CLK_DIV(CA)) u_dut_a (
    .clk     (clk),
    .reset   (reset),
    .i_data  (a_data),
    .i_last  (a_last),
    .i_valid (a_valid),
    .o_ready (a_ready),
    .o_busy  (a_busy),
    .o_cs    (a_cs),
    .o_sck   (a_sck),
    .o_mosi  (a_mosi)
  );

  silife_spi_word_tx #(.DATA_BITS(DB), .CLK_DIV(CB)) u_dut_b (
    .clk     (clk),
    .reset   (reset),
    .i_data  (b_data),
    .i_last  (b_last),
    .i_valid (b_valid),
    .o_ready (b_ready),
    .o_busy  (b_busy),
    .o_cs    (b_cs),
    .o_sck   (b_sck),
    .o_mosi  (b_mosi)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t_acc  = 0;
  int t_prev = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DA-1:0] data;
    logic          last;
    logic          keep;
    logic [DA-1:0] iso;
    int            exp_ready_k;
    int            exp_cs_low;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Reference timing, counted in samples after the accepting edge (sample 1 = first cycle).
  function automatic int model_ready_k(input logic l);
    return 1 + 2 * DA * CA + (l ? CA : 0);
  endfunction

  function automatic int model_cs_low(input logic l);
    return 2 * DA * CA + (l ? 0 : 1);
  endfunction

  // Send one word on instance A and observe the serial stream until ready returns.
  task automatic xfer_a(input logic [DA-1:0] d, input logic l, input logic keep,
                        input logic [DA-1:0] iso, input int exp_rk, input int exp_csl);
    int   k, rises, first_rise, cs_low, cs_rise, viol, val;
    logic psck, pmosi, pcs;
    bit   done;
    a_data  = d;
    a_last  = l;
    a_valid = 1'b1;
    k = 0;
    while (!a_ready && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk1("ready_before_accept", a_ready, 1'b1);
    @(posedge clk);
    t_prev = t_acc;
    t_acc  = cyc;
    #1;
    a_data = iso;
    a_last = ~l;
    if (!keep) a_valid = 1'b0;
    val = 0; rises = 0; first_rise = 0; cs_low = 0; cs_rise = 0; viol = 0;
    psck = 1'b0; pcs = 1'b0; pmosi = d[DA-1]; done = 1'b0;
    for (k = 1; k <= 400 && !done; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk1("start_cs", a_cs, 1'b0);
        chk1("start_sck", a_sck, 1'b0);
        chk1("start_mosi", a_mosi, d[DA-1]);
      end
      if (a_sck && !psck) begin
        val = (val << 1) | int'(a_mosi);
        rises++;
        if (first_rise == 0) first_rise = k;
      end
      if (a_mosi !== pmosi && !(psck && !a_sck)) viol++;
      if (a_cs && !pcs) cs_rise++;
      if (!a_cs) cs_low++;
      if (a_ready) begin
        chk("ready_k", k, exp_rk);
        done = 1'b1;
      end
      psck = a_sck; pmosi = a_mosi; pcs = a_cs;
    end
    if (!done) chk("ready_timeout", 0, 1);
    chk("mosi_value", val, 32'(d));
    chk("sck_rises", rises, DA);
    chk("first_rise_k", first_rise, CA + 1);
    chk("cs_rise_edges", cs_rise, l ? 1 : 0);
    chk("cs_low_cycles", cs_low, exp_csl);
    chk("mosi_change_off_fall", viol, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    vec_t tab [7];
    int   n, k, bad, gap, kb, brises, bhold, bval, bbad, lastrise;
    logic psck, bps, l, keep, prev_keep;
    logic [DA-1:0] d;
    bit   bdone;

    tab[0] = '{16'hA5C3, 1'b1, 1'b0, 16'h5A3C, 67, 64};
    tab[1] = '{16'h0C01, 1'b0, 1'b1, 16'hFFFF, 65, 65};
    tab[2] = '{16'h0C01, 1'b1, 1'b0, 16'h0000, 67, 64};
    tab[3] = '{16'h1234, 1'b1, 1'b0, 16'h0000, 67, 64};
    tab[4] = '{16'h8000, 1'b0, 1'b0, 16'h7FFF, 65, 65};
    tab[5] = '{16'h0001, 1'b0, 1'b1, 16'hFFFF, 65, 65};
    tab[6] = '{16'hFFFE, 1'b1, 1'b0, 16'h0001, 67, 64};

    a_data = '0; a_last = 1'b0; a_valid = 1'b0;
    b_data = '0; b_last = 1'b0; b_valid = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk1("rst_a_cs", a_cs, 1'b1);
    chk1("rst_a_sck", a_sck, 1'b0);
    chk1("rst_a_mosi", a_mosi, 1'b0);
    chk1("rst_a_ready", a_ready, 1'b1);
    chk1("rst_a_busy", a_busy, 1'b0);
    chk1("rst_b_cs", b_cs, 1'b1);
    chk1("rst_b_ready", b_ready, 1'b1);
    reset = 1'b1;
    @(negedge clk);

    // Directed table: single word, cascade, isolation, edge patterns.
    for (int i = 0; i < 7; i++) begin
      xfer_a(tab[i].data, tab[i].last, tab[i].keep, tab[i].iso,
             tab[i].exp_ready_k, tab[i].exp_cs_low);
      if (i > 0 && tab[i-1].keep) chk("b2b_gap", t_acc - t_prev, 2 * DA * CA + 1);
    end

    // Stalled WAIT: CS and SCK stay low indefinitely, then the frame resumes.
    xfer_a(16'h3C5A, 1'b0, 1'b0, 16'hFFFF, 65, 65);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (a_cs !== 1'b0 || a_sck !== 1'b0 || a_ready !== 1'b1 || a_busy !== 1'b1) bad++;
    end
    chk("stall_wait_bad_cycles", bad, 0);
    xfer_a(16'h0F0F, 1'b1, 1'b0, 16'hF0F0, 67, 64);

    // Reset mid-shift after the 5th SCK rise.
    a_data = 16'hF8F8; a_last = 1'b1; a_valid = 1'b1;
    @(posedge clk);
    #1 a_valid = 1'b0;
    n = 0; k = 0; psck = 1'b0;
    while (n < 5 && k < 200) begin
      @(negedge clk);
      k++;
      if (a_sck && !psck) n++;
      psck = a_sck;
    end
    chk("rst_mid_rises_seen", n, 5);
    reset = 1'b0;
    #1;
    chk1("rst_mid_cs", a_cs, 1'b1);
    chk1("rst_mid_sck", a_sck, 1'b0);
    chk1("rst_mid_mosi", a_mosi, 1'b0);
    chk1("rst_mid_ready", a_ready, 1'b1);
    chk1("rst_mid_busy", a_busy, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk1("rst_release_ready", a_ready, 1'b1);
    xfer_a(16'hFFFF, 1'b1, 1'b0, 16'h0000, 67, 64);

    // Random words against the timing model.
    prev_keep = 1'b0;
    for (int i = 0; i < 20; i++) begin
      d    = 16'($urandom);
      l    = (i == 19) ? 1'b1 : ($urandom_range(0, 3) == 0);
      keep = !l && ($urandom_range(0, 1) == 1);
      xfer_a(d, l, keep, 16'($urandom), model_ready_k(l), model_cs_low(l));
      if (prev_keep) chk("rand_b2b_gap", t_acc - t_prev, 2 * DA * CA + 1);
      prev_keep = keep;
      if (!keep) begin
        gap = $urandom_range(0, 4);
        repeat (gap) @(negedge clk);
      end
    end

    // Fastest divide on instance B.
    b_data = 8'h81; b_last = 1'b1; b_valid = 1'b1;
    @(posedge clk);
    #1;
    b_valid = 1'b0; b_data = 8'h00; b_last = 1'b0;
    brises = 0; bhold = 0; bval = 0; bbad = 0; lastrise = 0; bps = 1'b0; bdone = 1'b0;
    for (kb = 1; kb <= 60 && !bdone; kb++) begin
      @(negedge clk);
      if (b_sck && !bps) begin
        bval = (bval << 1) | int'(b_mosi);
        brises++;
        if (lastrise == 0) chk("b_first_rise_k", kb, CB + 1);
        else if (kb - lastrise != 2 * CB) bbad++;
        lastrise = kb;
      end
      if (b_cs && b_busy) bhold++;
      if (b_ready) begin
        chk("b_ready_k", kb, 1 + 2 * DB * CB + CB);
        bdone = 1'b1;
      end
      bps = b_sck;
    end
    if (!bdone) chk("b_ready_timeout", 0, 1);
    chk("b_mosi_value", bval, 32'h81);
    chk("b_sck_rises", brises, DB);
    chk("b_sck_period_bad", bbad, 0);
    chk("b_cs_hold_cycles", bhold, CB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
